// File: rtl/timer_pkg.sv
// Shared types, LS48-style segment patterns and modulus helpers for the BCD timer.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    typedef enum logic {
        ST_COUNT,
        ST_EXPIRED
    } mode_state_t;

    // Segment order {g,f,e,d,c,b,a}, active high; 6 and 9 are tail-less as on the LS48.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7C;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic bcd_pair_t bcd_terminal(input int modulus);
        bcd_pair_t r;
        r.tens = 4'((modulus - 1) / 10);
        r.ones = 4'((modulus - 1) % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// LS48-compatible BCD to 7-segment decoder; codes above 9 blank the digit.
module bcd_to_seg7
    import timer_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/timer_bcd_mod.sv
// Two-digit BCD timer with prescaler, modulus, up/down, load and wrap/one-shot modes.
// Define TIMER_LEAD_BLANK_EN to blank the tens digit on the display while it is zero.
module timer_bcd_mod
    import timer_pkg::*;
#(
    parameter int DIV  = 50_000_000,
    parameter int MOD  = 60,
    parameter int WRAP = 1
) (
    input  logic       CLK50M,
    input  logic       sys_rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens_bcd,
    output logic [3:0] ones_bcd,
    output logic [6:0] tens_seg,
    output logic [6:0] ones_seg,
    output logic       done,
    output logic       expired
);

    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam bcd_pair_t       TERM_HI  = bcd_terminal(MOD);
    localparam logic [7:0]      MOD_V    = 8'(MOD);
    localparam bit              ONE_SHOT = (WRAP == 0);

    logic [PW-1:0] pre_q, pre_d;
    bcd_t          tens_q, tens_d, ones_q, ones_d;
    logic          done_q, done_d;
    mode_state_t   state_q, state_d;

    logic          tick;
    logic [7:0]    load_val;
    logic          load_bad;
    logic          at_top, at_zero;
    bcd_t          inc_tens, inc_ones, dec_tens, dec_ones;
    logic          inc_is_top, dec_is_zero;
    logic [6:0]    tens_seg_raw;

    assign tick     = en && (pre_q == PRE_LAST);
    assign load_val = 8'(load_tens) * 8'd10 + 8'(load_ones);
    assign load_bad = (load_tens > 4'd9) || (load_ones > 4'd9) || (load_val >= MOD_V);
    assign at_top   = (tens_q == TERM_HI.tens) && (ones_q == TERM_HI.ones);
    assign at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Single-step BCD neighbours of the current value in both directions.
    always_comb begin
        inc_tens = tens_q;
        inc_ones = ones_q + 4'd1;
        if (ones_q == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = tens_q + 4'd1;
        end
        dec_tens = tens_q;
        dec_ones = ones_q - 4'd1;
        if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
        end
    end

    assign inc_is_top  = (inc_tens == TERM_HI.tens) && (inc_ones == TERM_HI.ones);
    assign dec_is_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);

    always_ff @(posedge CLK50M or posedge sys_rst) begin
        if (sys_rst) begin
            pre_q   <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
            state_q <= ST_COUNT;
        end else begin
            pre_q   <= pre_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    // In one-shot mode a tick that finds the value already at its terminal only
    // raises done and expired; the value itself never moves past the terminal.
    always_comb begin
        pre_d   = pre_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        state_d = state_q;

        if (load) begin
            pre_d   = '0;
            state_d = ST_COUNT;
            if (load_bad) begin
                tens_d = TERM_HI.tens;
                ones_d = TERM_HI.ones;
            end else begin
                tens_d = load_tens;
                ones_d = load_ones;
            end
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick && (state_q == ST_COUNT)) begin
                if (up) begin
                    if (at_top) begin
                        done_d = 1'b1;
                        if (ONE_SHOT) begin
                            state_d = ST_EXPIRED;
                        end else begin
                            tens_d = 4'd0;
                            ones_d = 4'd0;
                        end
                    end else begin
                        tens_d = inc_tens;
                        ones_d = inc_ones;
                        if (ONE_SHOT && inc_is_top) begin
                            done_d  = 1'b1;
                            state_d = ST_EXPIRED;
                        end
                    end
                end else begin
                    if (at_zero) begin
                        done_d = 1'b1;
                        if (ONE_SHOT) begin
                            state_d = ST_EXPIRED;
                        end else begin
                            tens_d = TERM_HI.tens;
                            ones_d = TERM_HI.ones;
                        end
                    end else begin
                        tens_d = dec_tens;
                        ones_d = dec_ones;
                        if (ONE_SHOT && dec_is_zero) begin
                            done_d  = 1'b1;
                            state_d = ST_EXPIRED;
                        end
                    end
                end
            end
        end
    end

    assign tens_bcd = tens_q;
    assign ones_bcd = ones_q;
    assign done     = done_q;
    assign expired  = (state_q == ST_EXPIRED);

    bcd_to_seg7 u_tens_dec (
        .digit (tens_q),
        .seg   (tens_seg_raw)
    );

    bcd_to_seg7 u_ones_dec (
        .digit (ones_q),
        .seg   (ones_seg)
    );

`ifdef TIMER_LEAD_BLANK_EN
    assign tens_seg = (tens_q == 4'd0) ? SEG_BLANK : tens_seg_raw;
`else
    assign tens_seg = tens_seg_raw;
`endif

endmodule

// File: tb/tb_timer_bcd_mod.sv
// Randomised scoreboard bench: four timer configurations share one stimulus stream
// and are compared every cycle against an integer-valued reference model.
module tb_timer_bcd_mod;

    localparam int N  = 4;
    localparam int D0 = 4, M0 = 60,  W0 = 1;
    localparam int D1 = 1, M1 = 10,  W1 = 0;
    localparam int D2 = 1, M2 = 100, W2 = 1;
    localparam int D3 = 2, M3 = 25,  W3 = 1;

    typedef struct {
        int val;
        int pre;
        bit expd;
        bit done;
    } mstate_t;

    typedef struct {
        int inst;
        int val;
        bit done;
        bit expd;
    } exp_t;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_tens = 4'd0, load_ones = 4'd0;

    logic [3:0] tens_bcd_w [N];
    logic [3:0] ones_bcd_w [N];
    logic [6:0] tens_seg_w [N];
    logic [6:0] ones_seg_w [N];
    logic       done_w     [N];
    logic       expired_w  [N];

    int      p_div [N] = '{D0, D1, D2, D3};
    int      p_mod [N] = '{M0, M1, M2, M3};
    int      p_wrap[N] = '{W0, W1, W2, W3};
    mstate_t model [N];
    exp_t    sb_q  [$];
    int      checks = 0;
    int      errors = 0;
    int      cycle  = 0;

    always #5 clk = ~clk;

    timer_bcd_mod #(.DIV(D0), .MOD(M0), .WRAP(W0)) u0 (
        .CLK50M(clk), .sys_rst(sys_rst), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens_bcd(tens_bcd_w[0]), .ones_bcd(ones_bcd_w[0]),
        .tens_seg(tens_seg_w[0]), .ones_seg(ones_seg_w[0]),
        .done(done_w[0]), .expired(expired_w[0]));

    timer_bcd_mod #(.DIV(D1), .MOD(M1), .WRAP(W1)) u1 (
        .CLK50M(clk), .sys_rst(sys_rst), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens_bcd(tens_bcd_w[1]), .ones_bcd(ones_bcd_w[1]),
        .tens_seg(tens_seg_w[1]), .ones_seg(ones_seg_w[1]),
        .done(done_w[1]), .expired(expired_w[1]));

    timer_bcd_mod #(.DIV(D2), .MOD(M2), .WRAP(W2)) u2 (
        .CLK50M(clk), .sys_rst(sys_rst), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens_bcd(tens_bcd_w[2]), .ones_bcd(ones_bcd_w[2]),
        .tens_seg(tens_seg_w[2]), .ones_seg(ones_seg_w[2]),
        .done(done_w[2]), .expired(expired_w[2]));

    timer_bcd_mod #(.DIV(D3), .MOD(M3), .WRAP(W3)) u3 (
        .CLK50M(clk), .sys_rst(sys_rst), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens_bcd(tens_bcd_w[3]), .ones_bcd(ones_bcd_w[3]),
        .tens_seg(tens_seg_w[3]), .ones_seg(ones_seg_w[3]),
        .done(done_w[3]), .expired(expired_w[3]));

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7C;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h67;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] tens_seg_of(input int d);
`ifdef TIMER_LEAD_BLANK_EN
        if (d == 0) return 7'h00;
`endif
        return seg_of(d);
    endfunction

    // Reference behaviour on a plain integer value 0..mod-1.
    function automatic mstate_t model_step(input mstate_t s, input int dv, input int md,
                                           input int wr, input bit e, input bit u,
                                           input bit ld, input int lt, input int lo);
        mstate_t n;
        int      term;
        int      v;
        n      = s;
        n.done = 1'b0;
        if (ld) begin
            v = lt * 10 + lo;
            if (lt > 9 || lo > 9 || v >= md) v = md - 1;
            n.val  = v;
            n.pre  = 0;
            n.expd = 1'b0;
        end else if (e) begin
            n.pre = (s.pre == dv - 1) ? 0 : s.pre + 1;
            if (s.pre == dv - 1 && !s.expd) begin
                if (wr != 0) begin
                    if (u) begin
                        n.val  = (s.val == md - 1) ? 0 : s.val + 1;
                        n.done = (s.val == md - 1);
                    end else begin
                        n.val  = (s.val == 0) ? md - 1 : s.val - 1;
                        n.done = (s.val == 0);
                    end
                end else begin
                    term = u ? md - 1 : 0;
                    if (s.val != term) n.val = u ? s.val + 1 : s.val - 1;
                    if (n.val == term) begin
                        n.done = 1'b1;
                        n.expd = 1'b1;
                    end
                end
            end
        end
        return n;
    endfunction

    task automatic check_output(input string name, input int inst, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s u%0d cycle %0d: got %0d, expected %0d", name, inst, cycle, act, req);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.inst = i;
            e.val  = model[i].val;
            e.done = model[i].done;
            e.expd = model[i].expd;
            sb_q.push_back(e);
        end
    endtask

    task automatic apply_stimulus(input bit e, input bit u, input bit ld,
                                  input int lt, input int lo);
        @(negedge clk);
        sys_rst   = 1'b0;
        en        = e;
        up        = u;
        load      = ld;
        load_tens = 4'(lt);
        load_ones = 4'(lo);
        for (int i = 0; i < N; i++)
            model[i] = model_step(model[i], p_div[i], p_mod[i], p_wrap[i], e, u, ld, lt, lo);
        push_expected();
    endtask

    // Reset lands between clock edges; outputs must clear before any edge arrives.
    task automatic apply_reset();
        @(negedge clk);
        sys_rst = 1'b1;
        load    = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check_output("rst_bcd", i, {tens_bcd_w[i], ones_bcd_w[i]}, 0);
            check_output("rst_done", i, done_w[i], 0);
            check_output("rst_expired", i, expired_w[i], 0);
            check_output("rst_tens_seg", i, tens_seg_w[i], tens_seg_of(0));
            check_output("rst_ones_seg", i, ones_seg_w[i], 7'h3F);
            model[i] = '{val: 0, pre: 0, expd: 1'b0, done: 1'b0};
        end
        push_expected();
    endtask

    // Monitor: every output is valid each cycle, so one scoreboard entry per instance is retired per edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cycle++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_output("bcd", e.inst, tens_bcd_w[e.inst] * 10 + ones_bcd_w[e.inst], e.val);
            check_output("ones_digit", e.inst, ones_bcd_w[e.inst] <= 9, 1);
            check_output("tens_seg", e.inst, tens_seg_w[e.inst], tens_seg_of(e.val / 10));
            check_output("ones_seg", e.inst, ones_seg_w[e.inst], seg_of(e.val % 10));
            check_output("done", e.inst, done_w[e.inst], e.done);
            check_output("expired", e.inst, expired_w[e.inst], e.expd);
        end
    end

    initial begin
        bit ld;
        int lt, lo;
        bit u_dir;
        repeat (2) @(negedge clk);
        apply_reset();

        // Long up-count: the DIV=4 timer wraps 59->00 near cycle 240.
        repeat (250) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);

        // Enable held low for 10-cycle stretches mid-count.
        for (int c = 0; c < 120; c++) apply_stimulus(((c / 10) % 3) != 1, 1'b1, 1'b0, 0, 0);

        // Count down from 07 through 00 and wrap to the top value.
        apply_stimulus(1'b1, 1'b0, 1'b1, 0, 7);
        repeat (120) apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);

        // Invalid load value selects MOD-1; disabled cycles then hold it.
        apply_stimulus(1'b0, 1'b0, 1'b1, 9, 9);
        repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0);

        // One-shot run to the terminal, direction flip while expired, then reload.
        apply_stimulus(1'b1, 1'b1, 1'b1, 0, 0);
        repeat (60) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);
        repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 0, 3);
        repeat (20) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);

        // Reset in the middle of a count.
        repeat (37) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);
        apply_reset();
        repeat (20) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);

        // Random traffic: loads (valid and invalid), direction changes, gaps, resets.
        u_dir = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end else begin
                if ($urandom_range(0, 49) == 0) u_dir = ~u_dir;
                ld = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 1) == 0) begin
                    lt = $urandom_range(0, 9);
                    lo = $urandom_range(0, 9);
                end else begin
                    lt = $urandom_range(0, 15);
                    lo = $urandom_range(0, 15);
                end
                apply_stimulus($urandom_range(0, 7) != 0, u_dir, ld, lt, lo);
            end
        end

        repeat (2) @(negedge clk);
        check_output("scoreboard_drained", 0, sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_bcd_mod.md
Name: timer_bcd_mod

Overview:
- Parametrised two-digit BCD timer; successor to the fixed 0–59 seconds timer.
- Adds programmable modulus, clock prescaler, up/down counting, synchronous load, wrap or one-shot mode, and a terminal-count pulse.
- Drives two LS48-style 7-segment digit outputs directly.
- Sits between the 50 MHz board clock and the display pins; also usable as a timebase for other blocks via done.

Parameters:
- DIV, 50_000_000: CLK50M cycles per count tick. Must be ≥1; DIV=1 gives one tick per enabled cycle.
- MOD, 60: count modulus. Legal 2..100; value range is 0..MOD-1.
- WRAP, 1: 1 = free-running wrap; 0 = one-shot, stops at the terminal value.

Ports:
- CLK50M  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable. While low, prescaler and value hold.
- up  in  1  direction: 1 = count up, 0 = count down. Sampled on each tick.
- load  in  1  synchronous load strobe.
- load_tens  in  4  BCD tens digit for load.
- load_ones  in  4  BCD ones digit for load.
- tens_bcd  out  4  current tens digit.
- ones_bcd  out  4  current ones digit.
- tens_seg  out  7  {g,f,e,d,c,b,a}, active-high, tens digit.
- ones_seg  out  7  same encoding, ones digit.
- done  out  1  one-cycle pulse on terminal transition.
- expired  out  1  level; one-shot mode only, high while stopped at terminal.

Behaviour:
- Reset (async assert, sync release):
  - tens/ones = 0, prescaler = 0, done = 0, expired = 0.
  - Segment outputs show "0 0" (7'h3F each), or blank per the Optional Feature.
- Prescaler:
  - Counts 0..DIV-1 on cycles with en=1.
  - tick = en && prescaler==DIV-1; prescaler returns to 0 on the same edge.
- Value update on tick, registered, effective at the tick edge:
  - Up: ones+1; at 9, ones←0 and tens+1.
  - Down: ones-1; at 0, ones←9 and tens-1.
  - Terminal (up) = MOD-1; terminal (down) = 0.
- WRAP=1:
  - Up at MOD-1 → 00 with done=1.
  - Down at 00 → MOD-1 with done=1.
- WRAP=0:
  - On reaching terminal, done=1 for that cycle and expired←1.
  - Further ticks are ignored, and done does not repeat.
  - Changing direction while expired does not restart counting; only load or reset clears expired.
- Load:
  - Highest priority after reset, independent of en.
  - Sets digits to load value, clears prescaler, clears expired, forces done=0.
  - Invalid value (digit >9 or value ≥MOD) loads MOD-1 instead.
  - Load and tick in the same cycle: load wins, tick is discarded.
- done timing: registered, high exactly the cycle after the tick edge, aligned with the new value.
- Segment outputs:
  - Combinational decode of the registered digits, zero added latency.
  - Digits >9 are unreachable; the decoder maps them to blank.
- Reset mid-count returns immediately to 00; no pending tick survives.

Optional Feature:
- Macro: TIMER_LEAD_BLANK_EN.
- Defined: tens_seg = 7'h00 whenever tens==0 (leading-zero blanking). ones_seg is unaffected, so 00 shows " 0".
- Undefined: tens digit is always displayed, e.g. "05".
- BCD outputs are identical in both builds.

Decomposition:
- Package timer_pkg:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - BCD digit typedef (4-bit).
  - Function computing MOD-1 as tens/ones BCD digits.
- Sub-module bcd_to_seg7: 4-bit in, 7-bit out, LS48-compatible; instantiated twice.
- Top holds prescaler, digit counters, mode logic.

Test Plan:
1. DIV=4, MOD=60, up=1, en=1 for 240 cycles from reset → value reaches 59 at tick 59. Next tick gives 00 with done high one cycle. ones_seg=7'h3F, tens_seg=7'h3F (or 00 with blanking).
2. DIV=4, en toggled low 10 cycles mid-count → value and prescaler frozen; resume continues the exact tick phase, no lost or extra tick.
3. MOD=25, up=0, load 07 → counts 06..00, then 24 with done pulse. Load 9/9 (invalid) → value 24.
4. WRAP=0, MOD=10, up=1 from 00 → stops at 09: done one pulse, expired held for 50 more ticks. Load 03 → expired clears and counting resumes.
5. Load asserted on the same cycle as a tick → loaded value appears and the tick is dropped. Assert sys_rst mid-count → outputs 00 asynchronously, done=0.
6. DIV=1, MOD=100 → increments every enabled cycle; 99→00 with done; BCD digits never exceed 9.
